// File: rtl/rca4_frame_accum.sv
// Frame accumulator behind the 4-bit ripple-carry adder: sums N_SAMPLES 5-bit results
// and presents each frame sum on a valid/ready output. Optional macro: ACC_SAT_EN (saturate).
module rca4_frame_accum #(
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_s,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(N_SAMPLES);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_valid_q, out_valid_d;

  logic [ACC_W-1:0]   operand;
  logic [ACC_W:0]     sum_ext;
  logic               ovf_acc;
  logic [ACC_W-1:0]   acc_new;
  logic               accept;

  // in_ready must drop the moment rst rises, so it looks at rst directly.
  assign in_ready  = (state_q == ST_ACC) && !rst;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    operand = ACC_W'({in_cout, in_s});
    sum_ext = {1'b0, acc_q} + {1'b0, operand};
    ovf_acc = ovf_q | sum_ext[ACC_W];
`ifdef ACC_SAT_EN
    // Once clamped, the accumulator stays at full scale until the frame ends.
    acc_new = ovf_acc ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_new = sum_ext[ACC_W-1:0];
`endif
    accept = in_valid && in_ready;

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (clr) begin
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            if (cnt_q == CNT_W'(N_SAMPLES - 1)) begin
              out_sum_d   = acc_new;
              out_ovf_d   = ovf_acc;
              out_valid_d = 1'b1;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
              state_d     = ST_HOLD;
            end else begin
              acc_d = acc_new;
              cnt_d = cnt_q + CNT_W'(1);
              ovf_d = ovf_acc;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_rca4_frame_accum.sv
// Self-checking bench for rca4_frame_accum: an 8-bit instance and a 6-bit instance
// share all inputs; expected frame sums come from integer totals of accepted beats.
module tb_rca4_frame_accum;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, in_cout, out_ready;
  logic [3:0] in_s;
  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_sum;
  logic       in_ready6, out_valid6, out_ovf6;
  logic [5:0] out_sum6;

  int checks = 0;
  int errors = 0;
  int frame_vals[8];

  always #5 clk = ~clk;

  rca4_frame_accum #(.N_SAMPLES(8), .ACC_W(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_cout(in_cout), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );

  rca4_frame_accum #(.N_SAMPLES(8), .ACC_W(6)) dut6 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready6),
    .in_s(in_s), .in_cout(in_cout), .out_valid(out_valid6), .out_ready(out_ready),
    .out_sum(out_sum6), .out_ovf(out_ovf6)
  );

  // Reference: frame result from the exact integer total of the accepted beats.
  function automatic int model_sum(input int total, input int w);
    int m;
    m = (1 << w) - 1;
`ifdef ACC_SAT_EN
    return (total > m) ? m : total;
`else
    return total % (m + 1);
`endif
  endfunction

  function automatic int model_ovf(input int total, input int w);
    return (total > (1 << w) - 1) ? 1 : 0;
  endfunction

  function automatic int frame_total();
    int t;
    t = 0;
    for (int i = 0; i < 8; i++) t += frame_vals[i];
    return t;
  endfunction

  task automatic beat(input int v);
    @(negedge clk);
    in_valid = 1'b1;
    {in_cout, in_s} = 5'(v);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      {in_cout, in_s} = 5'($urandom);
    end
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < 8; i++) begin
      idle(int'($urandom_range(max_gap, 0)));
      beat(frame_vals[i]);
    end
    idle(1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_frame(input string name);
    int t;
    t = frame_total();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %0d expected 1", name, out_valid); end
    checks++; if (out_sum !== 8'(model_sum(t, 8))) begin errors++; $display("FAIL %s_sum: got %0d expected %0d", name, out_sum, model_sum(t, 8)); end
    checks++; if (out_ovf !== 1'(model_ovf(t, 8))) begin errors++; $display("FAIL %s_ovf: got %0d expected %0d", name, out_ovf, model_ovf(t, 8)); end
    checks++; if (out_sum6 !== 6'(model_sum(t, 6))) begin errors++; $display("FAIL %s_sum6: got %0d expected %0d", name, out_sum6, model_sum(t, 6)); end
    checks++; if (out_ovf6 !== 1'(model_ovf(t, 6))) begin errors++; $display("FAIL %s_ovf6: got %0d expected %0d", name, out_ovf6, model_ovf(t, 6)); end
    $display("frame %s: total=%0d sum=%0d ovf=%0d sum6=%0d ovf6=%0d", name, t, out_sum, out_ovf, out_sum6, out_ovf6);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0d expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0d expected 0", out_valid); end
    checks++; if (out_sum !== 8'd0) begin errors++; $display("FAIL rst_out_sum: got %0d expected 0", out_sum); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0d expected 1", in_ready); end
    $display("reset: in_ready=%0d after release", in_ready);
  endtask

  task automatic test_full_scale();
    for (int i = 0; i < 8; i++) begin
      beat(31);
      frame_vals[i] = 31;
      if (i == 7) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %0d expected 0", out_valid); end
      end
    end
    idle(1);
    check_frame("full_scale");
    checks++; if (out_sum !== 8'd248) begin errors++; $display("FAIL full_248: got %0d expected 248", out_sum); end
    consume();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after: got %0d expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_valid_after: got %0d expected 0", out_valid); end
    checks++; if (out_sum !== 8'd248) begin errors++; $display("FAIL full_sum_kept: got %0d expected 248", out_sum); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 3; i++) beat(int'($urandom_range(31, 1)));
    idle(1);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0d expected 0", out_valid); end
    checks++; if (out_sum !== 8'd0) begin errors++; $display("FAIL midrst_sum: got %0d expected 0", out_sum); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %0d expected 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) frame_vals[i] = int'($urandom_range(31, 0));
    send_frame(0);
    check_frame("after_reset");
    consume();
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 8; i++) frame_vals[i] = i;
    send_frame(3);
    check_frame("gaps_0to7");
    checks++; if (out_sum !== 8'd28) begin errors++; $display("FAIL gaps_28: got %0d expected 28", out_sum); end
    consume();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) frame_vals[i] = int'($urandom_range(31, 0));
      send_frame(2);
      check_frame($sformatf("random%0d", f));
      consume();
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) frame_vals[i] = 31;
    send_frame(0);
    check_frame("bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      {in_cout, in_s} = 5'($urandom);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %0d expected 1", out_valid); end
      checks++; if (out_sum !== 8'd248) begin errors++; $display("FAIL bp_sum_held: got %0d expected 248", out_sum); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0d expected 0", in_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %0d expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %0d expected 0", out_valid); end
    for (int i = 0; i < 8; i++) frame_vals[i] = 1;
    send_frame(0);
    check_frame("bp_next");
    consume();
  endtask

  task automatic test_abort();
    for (int i = 0; i < 3; i++) beat(5);
    @(negedge clk);
    clr = 1'b1;
    in_valid = 1'b1;
    {in_cout, in_s} = 5'd31;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %0d expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %0d expected 1", in_ready); end
    for (int i = 0; i < 8; i++) frame_vals[i] = 2;
    send_frame(0);
    check_frame("abort_acc");
    checks++; if (out_sum !== 8'd16) begin errors++; $display("FAIL abort_16: got %0d expected 16", out_sum); end
    consume();
    for (int i = 0; i < 8; i++) frame_vals[i] = 31;
    send_frame(0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_hold_valid: got %0d expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_hold_ready: got %0d expected 1", in_ready); end
    for (int i = 0; i < 8; i++) frame_vals[i] = 3;
    send_frame(1);
    check_frame("abort_hold_next");
    consume();
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    in_valid = 1'b0;
    in_cout = 1'b0;
    in_s = 4'd0;
    out_ready = 1'b0;
    test_reset();
    test_full_scale();
    test_reset_midframe();
    test_gaps();
    test_backpressure();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
